// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-ported data memory between the pipeline MEM stage and a
// host/debug loader; the CPU wins unless the host has been starved STARVE_MAX cycles.
module dmem_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 512,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  input  logic              cpu_MemWrite,
  input  logic              cpu_MemRead,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_write_data,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_read_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  starveCnt_q;
  logic              hostAck_q;
  logic              hostErr_q;
  logic [DATA_W-1:0] hostRdata_q;

  logic cpuAcc;
  logic hostElig;
  logic hostGnt;
  logic inRange;

  // Gating eligibility with rst_n keeps every grant and strobe low while in reset.
  assign cpuAcc   = cpu_MemRead | cpu_MemWrite;
  assign hostElig = rst_n & host_req & (state_q == IDLE);
  assign hostGnt  = hostElig & (~cpuAcc | (starveCnt_q >= CNT_MAX));
  assign inRange  = {1'b0, host_address} < DEPTH_L;

  always_comb begin
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    mem_MemWrite   = rst_n & cpu_MemWrite;
    mem_MemRead    = rst_n & cpu_MemRead;
    if (hostGnt) begin
      mem_address    = host_address;
      mem_write_data = host_write_data;
      mem_MemWrite   = host_we & inRange;
      mem_MemRead    = ~host_we & inRange;
    end
  end

  assign cpu_stall     = cpuAcc & hostGnt;
  assign cpu_read_data = (rst_n & ~hostGnt) ? mem_read_data : '0;

  assign host_ack       = hostAck_q;
  assign host_err       = hostErr_q;
  assign host_read_data = hostRdata_q;

  // A grant always lands in ACK, so a still-held request cannot be serviced twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      hostAck_q   <= 1'b0;
      hostErr_q   <= 1'b0;
      hostRdata_q <= '0;
    end else begin
      hostAck_q <= hostGnt;
      hostErr_q <= hostGnt & ~inRange;
      if (hostGnt) begin
        state_q     <= ACK;
        starveCnt_q <= '0;
        if (!inRange) begin
          hostRdata_q <= '0;
        end else if (!host_we) begin
          hostRdata_q <= mem_read_data;
        end
      end else begin
        state_q <= IDLE;
        if (hostElig && (starveCnt_q < CNT_MAX)) begin
          starveCnt_q <= starveCnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 512x16 memory on the
// memory side; each task owns one scenario and its inline checks.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_address;
  logic [15:0] cpu_write_data;
  logic        cpu_MemWrite;
  logic        cpu_MemRead;
  logic [15:0] cpu_read_data;
  logic        cpu_stall;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_address;
  logic [15:0] host_write_data;
  logic        host_ack;
  logic        host_err;
  logic [15:0] host_read_data;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [15:0] mem_read_data;

  logic [15:0] memArray [0:511];

  int errors = 0;
  int checks = 0;

  dmem_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_MemWrite   (cpu_MemWrite),
    .cpu_MemRead    (cpu_MemRead),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_address   (host_address),
    .host_write_data(host_write_data),
    .host_ack       (host_ack),
    .host_err       (host_err),
    .host_read_data (host_read_data),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_MemWrite   (mem_MemWrite),
    .mem_MemRead    (mem_MemRead),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_MemWrite) memArray[mem_address[8:0]] <= mem_write_data;
  end
  assign mem_read_data = memArray[mem_address[8:0]];

  task automatic cpu_idle();
    cpu_MemRead    = 1'b0;
    cpu_MemWrite   = 1'b0;
    cpu_address    = 16'h0000;
    cpu_write_data = 16'h0000;
  endtask

  // Issues one host transaction with the CPU idle and waits (bounded) for host_ack.
  task automatic host_txn(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output logic err, output logic [15:0] rdata,
                          output logic gntWr, output logic timedOut);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_address = addr; host_write_data = data;
    #2 gntWr = mem_MemWrite;
    lat = 0; err = 1'b0; rdata = 16'h0000; timedOut = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (host_ack) begin
        lat = i; err = host_err; rdata = host_read_data; timedOut = 1'b0;
        host_req = 1'b0;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_MemRead = 1'b1; cpu_address = 16'h0010;
    host_req = 1'b1; host_we = 1'b1; host_address = 16'h0001; host_write_data = 16'h1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_stall, host_ack, host_err, mem_MemWrite, mem_MemRead} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: stall/ack/err/wr/rd=%b required 00000",
               {cpu_stall, host_ack, host_err, mem_MemWrite, mem_MemRead});
    end
    checks++;
    if (host_read_data !== 16'h0000 || cpu_read_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data: host_read_data=%h cpu_read_data=%h required 0000 0000",
               host_read_data, cpu_read_data);
    end
    host_req = 1'b0;
    cpu_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_only();
    logic anyStall;
    logic anyAck;
    anyStall = 1'b0; anyAck = 1'b0;
    @(posedge clk); #1;
    cpu_MemWrite = 1'b1; cpu_address = 16'h0010; cpu_write_data = 16'hBEEF;
    #2;
    anyStall |= cpu_stall; anyAck |= host_ack;
    checks++;
    if (mem_MemWrite !== 1'b1 || mem_address !== 16'h0010 || mem_write_data !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL cpu_write_pass: wr=%b addr=%h data=%h required 1 0010 BEEF",
               mem_MemWrite, mem_address, mem_write_data);
    end
    @(posedge clk); #1;
    cpu_MemWrite = 1'b0; cpu_MemRead = 1'b1; cpu_address = 16'h0010;
    #2;
    anyStall |= cpu_stall; anyAck |= host_ack;
    checks++;
    if (cpu_read_data !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL cpu_read: cpu_read_data=%h required BEEF", cpu_read_data);
    end
    @(posedge clk); #1;
    cpu_idle();
    anyStall |= cpu_stall; anyAck |= host_ack;
    checks++;
    if (anyStall !== 1'b0 || anyAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_only_quiet: stall_seen=%b ack_seen=%b required 0 0", anyStall, anyAck);
    end
  endtask

  task automatic test_host_idle();
    int lat; logic err; logic [15:0] rdata; logic gntWr; logic tmo;
    host_txn(1'b1, 16'h01FF, 16'h1234, lat, err, rdata, gntWr, tmo);
    checks++;
    if (tmo || lat != 1 || err !== 1'b0 || gntWr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL host_write: timeout=%b latency=%0d err=%b memwr=%b required 0 1 0 1",
               tmo, lat, err, gntWr);
    end
    host_txn(1'b0, 16'h01FF, 16'h0000, lat, err, rdata, gntWr, tmo);
    checks++;
    if (tmo || lat != 1 || err !== 1'b0 || rdata !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL host_read: timeout=%b latency=%0d err=%b data=%h required 0 1 0 1234",
               tmo, lat, err, rdata);
    end
  endtask

  task automatic test_starvation();
    logic [6:0] stallSeen;
    logic [6:0] ackSeen;
    logic [15:0] ackData;
    logic [15:0] gntAddr;
    logic [2:0]  cntAfter;
    stallSeen = '0; ackSeen = '0; ackData = 16'h0000; gntAddr = 16'h0000; cntAfter = 3'd7;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        cpu_MemRead = 1'b1; cpu_address = 16'h0020;
        host_req = 1'b1; host_we = 1'b0; host_address = 16'h0010;
      end
      ackSeen[c] = host_ack;
      if (host_ack) begin
        ackData = host_read_data;
        host_req = 1'b0;
      end
      #2;
      stallSeen[c] = cpu_stall;
      if (c == 4) gntAddr = mem_address;
      if (c == 5) cntAfter = dut.starveCnt_q;
    end
    cpu_idle();
    host_req = 1'b0;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (stallSeen[c] !== (c == 4)) begin
        errors++;
        $display("[TB] FAIL starve_stall_c%0d: cpu_stall=%b required %b", c, stallSeen[c], (c == 4));
      end
    end
    checks++;
    if (ackSeen !== 7'b0100000) begin
      errors++;
      $display("[TB] FAIL starve_ack: ack pattern=%b required 0100000", ackSeen);
    end
    checks++;
    if (gntAddr !== 16'h0010 || ackData !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL starve_data: grant addr=%h ack data=%h required 0010 BEEF", gntAddr, ackData);
    end
    checks++;
    if (cntAfter !== 3'd0) begin
      errors++;
      $display("[TB] FAIL starve_cnt_clear: starve_cnt=%0d required 0", cntAfter);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic err; logic [15:0] rdata; logic gntWr; logic tmo;
    host_txn(1'b1, 16'h0200, 16'hFFFF, lat, err, rdata, gntWr, tmo);
    checks++;
    if (tmo || lat != 1 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oor_ack: timeout=%b latency=%0d err=%b required 0 1 1", tmo, lat, err);
    end
    checks++;
    if (gntWr !== 1'b0 || memArray[0] !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL oor_nowrite: memwr=%b mem[0]=%h required 0 0000", gntWr, memArray[0]);
    end
  endtask

  task automatic test_held_request();
    logic [5:0] ackSeen;
    logic [5:0] gntSeen;
    ackSeen = '0; gntSeen = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        host_req = 1'b1; host_we = 1'b0; host_address = 16'h01FF;
      end
      ackSeen[c] = host_ack;
      #2;
      gntSeen[c] = mem_MemRead;
    end
    @(posedge clk); #1;
    host_req = 1'b0;
    checks++;
    if (gntSeen !== 6'b010101) begin
      errors++;
      $display("[TB] FAIL held_grant: grant pattern=%b required 010101", gntSeen);
    end
    checks++;
    if (ackSeen !== 6'b101010) begin
      errors++;
      $display("[TB] FAIL held_ack: ack pattern=%b required 101010", ackSeen);
    end
  endtask

  task automatic test_reset_mid();
    logic gnt;
    logic ackEver;
    ackEver = 1'b0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_address = 16'h0010;
    #2 gnt = mem_MemRead;
    #2 rst_n = 1'b0;
    cpu_MemRead = 1'b1; cpu_address = 16'h0010;
    #1;
    checks++;
    if (gnt !== 1'b1 || host_read_data !== 16'h0000 || mem_MemRead !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: granted=%b host_read_data=%h memrd=%b stall=%b required 1 0000 0 0",
               gnt, host_read_data, mem_MemRead, cpu_stall);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      ackEver |= host_ack;
    end
    checks++;
    if (ackEver !== 1'b0 || dut.starveCnt_q !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_drop: ack_seen=%b starve_cnt=%0d required 0 0", ackEver, dut.starveCnt_q);
    end
    host_req = 1'b0;
    cpu_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    ackEver |= host_ack;
    cpu_MemWrite = 1'b1; cpu_address = 16'h0030; cpu_write_data = 16'h5A5A;
    #2;
    checks++;
    if (cpu_stall !== 1'b0 || mem_MemWrite !== 1'b1 || ackEver !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_cpu_write: stall=%b memwr=%b ack_seen=%b required 0 1 0",
               cpu_stall, mem_MemWrite, ackEver);
    end
    @(posedge clk); #1;
    cpu_MemWrite = 1'b0; cpu_MemRead = 1'b1;
    #2;
    checks++;
    if (cpu_read_data !== 16'h5A5A || cpu_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_cpu_read: data=%h stall=%b required 5A5A 0", cpu_read_data, cpu_stall);
    end
    @(posedge clk); #1;
    cpu_idle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) memArray[i] = 16'h0000;
    cpu_idle();
    host_req = 1'b0; host_we = 1'b0; host_address = 16'h0000; host_write_data = 16'h0000;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_cpu_only();
    test_host_idle();
    test_starvation();
    test_out_of_range();
    test_held_request();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported 512x16 data memory between two requesters: the pipeline MEM stage (CPU port) and a host/debug loader port (host port).
- CPU has priority by default. A starvation counter forces a host grant after STARVE_MAX denied cycles, and stalls the pipeline for that cycle.
- Sits between the MEM stage and the data memory. It drives the memory's address, write_data, MemWrite and MemRead inputs, and consumes its asynchronous read_data.

Parameters:
- DATA_W, 16, data width.
- ADDR_W, 16, address width on all ports.
- DEPTH, 512, valid host word addresses are 0..DEPTH-1.
- STARVE_MAX, 4, consecutive denied host-request cycles before a forced host grant (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_address  in  ADDR_W  MEM-stage address.
- cpu_write_data  in  DATA_W  MEM-stage store data.
- cpu_MemWrite  in  1  store request.
- cpu_MemRead  in  1  load request.
- cpu_read_data  out  DATA_W  load data (combinational).
- cpu_stall  out  1  MEM-stage access denied this cycle; pipeline holds.
- host_req  in  1  host request; held with stable fields until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_address  in  ADDR_W  host word address.
- host_write_data  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_err  out  1  valid with host_ack: address out of range.
- host_read_data  out  DATA_W  registered read data, valid with host_ack.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_MemWrite  out  1  to memory MemWrite.
- mem_MemRead  out  1  to memory MemRead.
- mem_read_data  in  DATA_W  from memory read_data.

Behaviour:
- Definitions:
  - cpu_acc = cpu_MemRead | cpu_MemWrite.
  - host_elig = host_req & (state==IDLE).
- Host FSM states:
  - IDLE -> ACK on a host grant.
  - ACK -> IDLE unconditionally after 1 cycle.
  - The host is never eligible in ACK, so a held host_req is not double-serviced.
- Grant, combinational each cycle: host_gnt = host_elig & (~cpu_acc | starve_cnt>=STARVE_MAX). The CPU is granted otherwise.
- Memory drive when host_gnt:
  - mem_address = host_address.
  - mem_write_data = host_write_data.
  - mem_MemWrite = host_we & in_range.
  - mem_MemRead = ~host_we & in_range.
  - in_range = host_address < DEPTH.
- Memory drive otherwise: CPU signals pass through unchanged. The CPU address is not range-checked; the memory uses the low address bits.
- Idle (no grant, no cpu_acc): mem_MemWrite = mem_MemRead = 0; address and data pass through from the CPU.
- CPU outputs:
  - cpu_stall = cpu_acc & host_gnt.
  - cpu_read_data = mem_read_data when the CPU is granted, else 0.
- Host transaction timing:
  - The write commits at the rising edge ending the grant cycle.
  - Read data is captured into host_read_data at that same edge.
  - host_ack = 1 in the following cycle (ACK), for exactly one cycle. Latency from grant to ack = 1 cycle.
  - host_err is registered at the same edge: 1 if ~in_range.
  - When host_err = 1: no memory write, and host_read_data = 0.
- host_read_data holds its value until the next host read completes.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, each cycle host_elig & ~host_gnt.
  - Clears to 0 on host_gnt.
  - Holds when host_req = 0.
- A forced grant stalls the CPU for exactly one cycle. The next cycle starve_cnt = 0 and the FSM is in ACK, so the CPU is granted.
- Simultaneous CPU MemRead & MemWrite: passed through as-is (memory writes and reads the old value). No arbitration difference.
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE, starve_cnt = 0, host_ack = 0, host_err = 0, host_read_data = 0.
  - While rst_n = 0: host_gnt = 0, cpu_stall = 0, mem_MemWrite = 0, mem_MemRead = 0.
  - A host request in flight is dropped without ack; the host re-issues it.
- Output reset values: cpu_stall 0, cpu_read_data 0 (no read), host_ack 0, host_err 0, host_read_data 0, mem_MemWrite 0, mem_MemRead 0.

Test Plan:
- CPU-only traffic:
  - cpu_MemWrite addr 0x0010 data 0xBEEF, then cpu_MemRead 0x0010 -> cpu_read_data = 0xBEEF.
  - cpu_stall stays 0 throughout.
  - host_ack stays 0 throughout.
- Host on idle bus:
  - host_req, we=1, addr 0x01FF, data 0x1234 -> host_ack pulses 1 cycle later, host_err = 0.
  - Host read of 0x01FF -> host_read_data = 0x1234 with host_ack.
- Starvation with STARVE_MAX=4:
  - cpu_MemRead every cycle, host_req held from cycle 0.
  - Required: host granted in cycle 4, cpu_stall = 1 only in cycle 4, host_ack in cycle 5.
  - Required: no stall in cycle 5, starve_cnt = 0.
- Out-of-range host access:
  - Host write addr 0x0200 data 0xFFFF -> host_ack = 1 with host_err = 1.
  - Memory word 0x0000 is unchanged (still 0).
  - mem_MemWrite is never asserted.
- Held request:
  - host_req held high across the ack cycle -> the second transaction is granted no earlier than the cycle after ACK.
  - Exactly one ack per grant.
- Reset mid-transaction:
  - Assert rst_n = 0 asynchronously between the host grant edge and the ack.
  - Required: host_ack never pulses, host_read_data = 0, starve_cnt = 0.
  - After release, CPU access passes with cpu_stall = 0.
